dmix_mixer: RTL and testbench

//   N-input, NUM_CH-channel digital mixer between the ringbuffered_resampler

---
 rtl/dmix_mixer_pkg.sv | 19 +
 rtl/mix_mac_sat.sv | 39 +++
 rtl/dmix_mixer.sv | 175 +++++++++++++++++
 tb/tb_dmix_mixer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmix_mixer_pkg.sv
// rtl/dmix_mixer_pkg.sv - shared constants for the dmix mixer: sample width, saturation limits, FSM encodings
package dmix_mixer_pkg;

    localparam int          SAMP_W  = 24;
    localparam logic [23:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [23:0] SAT_MIN = 24'h800000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_MAC  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Q1.(vol_width-1) unity gain for a given gain width
    function automatic int unity_gain(input int vol_width);
        return 1 << (vol_width - 1);
    endfunction

endpackage

// File: rtl/mix_mac_sat.sv
// rtl/mix_mac_sat.sv - combinational gain multiply, floor shift, accumulate and 24-bit saturation
module mix_mac_sat
    import dmix_mixer_pkg::*;
#(
    parameter int VOL_WIDTH = 16,
    parameter int ACC_W     = 26
) (
    input  logic signed [SAMP_W-1:0] i_samp,
    input  logic        [VOL_WIDTH-1:0] i_vol,
    input  logic                     i_mute,
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [ACC_W-1:0]  o_acc_next,
    output logic        [SAMP_W-1:0] o_sat
);

    localparam int PROD_W = SAMP_W + VOL_WIDTH + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'($signed(SAT_MAX));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'($signed(SAT_MIN));

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;
    logic signed [ACC_W-1:0]  w_term;

    // gain is unsigned, so it is zero-extended before the signed multiply; >>> floors
    always_comb begin
        w_prod     = PROD_W'(i_samp) * PROD_W'($signed({1'b0, i_vol}));
        w_shift    = w_prod >>> (VOL_WIDTH - 1);
        w_term     = i_mute ? '0 : ACC_W'(w_shift);
        o_acc_next = i_acc + w_term;
        if (o_acc_next > ACC_MAX) begin
            o_sat = SAT_MAX;
        end else if (o_acc_next < ACC_MIN) begin
            o_sat = SAT_MIN;
        end else begin
            o_sat = o_acc_next[SAMP_W-1:0];
        end
    end

endmodule

// File: rtl/dmix_mixer.sv
// rtl/dmix_mixer.sv - N-source gain mixer with pop/ack handshake, saturation and underrun timeout
module dmix_mixer
    import dmix_mixer_pkg::*;
#(
    parameter int NUM_IN      = 2,
    parameter int NUM_IN_LOG2 = 1,
    parameter int NUM_CH      = 2,
    parameter int NUM_CH_LOG2 = 1,
    parameter int VOL_WIDTH   = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 pop_i,
    output logic [SAMP_W-1:0]                 data_o,
    output logic [NUM_CH-1:0]                 ack_o,
    output logic [NUM_IN*NUM_CH-1:0]          src_pop_o,
    input  logic [NUM_IN*NUM_CH-1:0]          src_ack_i,
    input  logic [NUM_IN*SAMP_W-1:0]          src_data_i,
    input  logic [NUM_IN*NUM_CH*VOL_WIDTH-1:0] vol_i,
    input  logic [NUM_IN-1:0]                 mute_i,
    output logic [NUM_IN-1:0]                 underrun_o,
    input  logic                              clr_i
);

    localparam int ACC_W = SAMP_W + NUM_IN_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 2);
    // sources get TIMEOUT cycles beyond the first cycle a registered ack could land
    localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(TIMEOUT + 1);

    logic [2:0]               r_state;
    logic [NUM_CH-1:0]        r_pending;
    logic [NUM_CH_LOG2-1:0]   r_ch;
    logic [NUM_IN-1:0]        r_got;
    logic signed [SAMP_W-1:0] r_samp [NUM_IN];
    logic [TMR_W-1:0]         r_timer;
    logic [NUM_IN_LOG2-1:0]   r_mac_idx;
    logic signed [ACC_W-1:0]  r_acc;

    logic [NUM_CH-1:0]        w_pend;
    logic [NUM_CH_LOG2-1:0]   w_pick_ch;
    logic [NUM_CH-1:0]        w_take_mask;
    logic [NUM_IN-1:0]        w_ack_ch;
    logic [NUM_IN-1:0]        w_got_next;
    logic                     w_all_got;
    logic                     w_expire;
    logic signed [SAMP_W-1:0] w_mac_samp;
    logic [VOL_WIDTH-1:0]     w_mac_vol;
    logic                     w_mac_mute;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [SAMP_W-1:0]        w_sat;

    // request selection: pops arriving this cycle are visible to IDLE immediately
    always_comb begin
        w_pend      = r_pending | pop_i;
        w_pick_ch   = '0;
        w_take_mask = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_pend[c]) w_pick_ch = NUM_CH_LOG2'(c);
        end
        if (r_state == ST_IDLE && |w_pend) w_take_mask[w_pick_ch] = 1'b1;
    end

    // per-source ack on the channel in service, and the MAC operand mux
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_ack_ch[i] = src_ack_i[i*NUM_CH + int'(r_ch)];
        end
        w_got_next = r_got | w_ack_ch;
        w_all_got  = &w_got_next;
        w_expire   = (r_timer == TMR_EXPIRE);
        w_mac_samp = r_samp[r_mac_idx];
        w_mac_vol  = vol_i[(int'(r_mac_idx)*NUM_CH + int'(r_ch))*VOL_WIDTH +: VOL_WIDTH];
        w_mac_mute = mute_i[r_mac_idx];
    end

    mix_mac_sat #(
        .VOL_WIDTH (VOL_WIDTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .i_samp     (w_mac_samp),
        .i_vol      (w_mac_vol),
        .i_mute     (w_mac_mute),
        .i_acc      (r_acc),
        .o_acc_next (w_acc_next),
        .o_sat      (w_sat)
    );

    // pending requests: merge new pops, drop the one IDLE just took
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend & ~w_take_mask;
        end
    end

    // sticky underrun flags; a timeout in the same cycle as clr_i keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_o <= '0;
        end else if (r_state == ST_WAIT && !w_all_got && w_expire) begin
            underrun_o <= (clr_i ? '0 : underrun_o) | ~w_got_next;
        end else if (clr_i) begin
            underrun_o <= '0;
        end
    end

    // service FSM: pop sources, gather samples, accumulate, present result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_got     <= '0;
            r_timer   <= '0;
            r_mac_idx <= '0;
            r_acc     <= '0;
            data_o    <= '0;
            ack_o     <= '0;
            src_pop_o <= '0;
            for (int i = 0; i < NUM_IN; i++) r_samp[i] <= '0;
        end else begin
            src_pop_o <= '0;
            ack_o     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pend) begin
                        r_ch <= w_pick_ch;
                        for (int i = 0; i < NUM_IN; i++) begin
                            src_pop_o[i*NUM_CH + int'(w_pick_ch)] <= 1'b1;
                        end
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_got   <= '0;
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_got   <= w_got_next;
                    r_timer <= r_timer + TMR_W'(1);
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (w_ack_ch[i] && !r_got[i]) begin
                            r_samp[i] <= src_data_i[i*SAMP_W +: SAMP_W];
                        end else if (w_expire && !w_got_next[i]) begin
                            r_samp[i] <= '0;
                        end
                    end
                    if (w_all_got || w_expire) begin
                        r_acc     <= '0;
                        r_mac_idx <= '0;
                        r_state   <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc     <= w_acc_next;
                    r_mac_idx <= r_mac_idx + NUM_IN_LOG2'(1);
                    if (r_mac_idx == NUM_IN_LOG2'(NUM_IN - 1)) begin
                        data_o      <= w_sat;
                        ack_o[r_ch] <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmix_mixer.sv
// tb/tb_dmix_mixer.sv - scoreboard bench for dmix_mixer with directed vectors
module tb_dmix_mixer;

    localparam int NUM_IN  = 2;
    localparam int NUM_CH  = 2;
    localparam int VW      = 16;
    localparam int TIMEOUT = 255;
    localparam logic [VW-1:0] UNITY = 16'h8000;
    localparam logic [VW-1:0] HALF  = 16'h4000;

    typedef struct {
        logic [1:0]  ack;
        logic [23:0] data;
        int          cyc;
        int          tag;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic [NUM_CH-1:0]            pop_i;
    logic [23:0]                  data_o;
    logic [NUM_CH-1:0]            ack_o;
    logic [NUM_IN*NUM_CH-1:0]     src_pop_o;
    logic [NUM_IN*NUM_CH-1:0]     src_ack_i;
    logic [NUM_IN*24-1:0]         src_data_i;
    logic [NUM_IN*NUM_CH*VW-1:0]  vol_i;
    logic [NUM_IN-1:0]            mute_i;
    logic [NUM_IN-1:0]            underrun_o;
    logic                         clr_i;

    logic [NUM_IN*NUM_CH-1:0]     prev_pop;
    logic [NUM_IN-1:0]            src_en;
    exp_t                         sb[$];
    int                           cyc;
    int                           n_vec;
    int                           n_bad;
    int                           tag_cnt;

    dmix_mixer #(
        .NUM_IN      (NUM_IN),
        .NUM_IN_LOG2 (1),
        .NUM_CH      (NUM_CH),
        .NUM_CH_LOG2 (1),
        .VOL_WIDTH   (VW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (pop_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .src_pop_o  (src_pop_o),
        .src_ack_i  (src_ack_i),
        .src_data_i (src_data_i),
        .vol_i      (vol_i),
        .mute_i     (mute_i),
        .underrun_o (underrun_o),
        .clr_i      (clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // sources answer a pop with a one-cycle ack in the following cycle
    initial begin
        prev_pop  = '0;
        src_ack_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_IN; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    src_ack_i[i*NUM_CH + c] = prev_pop[i*NUM_CH + c] & src_en[i];
                end
            end
            prev_pop = src_pop_o;
        end
    end

    // monitor: every ack_o pulse is matched against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack_o !== '0) begin
                n_vec = n_vec + 1;
                if (sb.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_ack cyc=%0d ack_o=%b data_o=%h required no ack", cyc, ack_o, data_o);
                end else begin
                    e = sb.pop_front();
                    if (ack_o !== e.ack || data_o !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                        n_bad = n_bad + 1;
                        $display("FAIL vec%0d ack=%b data=%h cyc=%0d required ack=%b data=%h cyc=%0d",
                                 e.tag, ack_o, data_o, cyc, e.ack, e.data, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] ack, input logic [23:0] data, input int at_cyc);
        exp_t e;
        e.ack  = ack;
        e.data = data;
        e.cyc  = at_cyc;
        e.tag  = tag_cnt;
        tag_cnt = tag_cnt + 1;
        sb.push_back(e);
    endtask

    // one-cycle pop; lat < 0 means the ack cycle is not checked, exp_ack 0 means no ack expected
    task automatic issue(input logic [1:0] mask, input logic [1:0] exp_ack, input logic [23:0] exp_data, input int lat);
        @(posedge clk);
        #1;
        pop_i = mask;
        if (exp_ack != 2'b00) push_exp(exp_ack, exp_data, (lat < 0) ? -1 : cyc + lat);
        @(posedge clk);
        #1;
        pop_i = '0;
    endtask

    task automatic drain(input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n = n + 1;
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL vec%0d timeout no ack_o, required ack=%b data=%h", e.tag, e.ack, e.data);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic set_vol(input int i, input int c, input logic [VW-1:0] v);
        vol_i[(i*NUM_CH + c)*VW +: VW] = v;
    endtask

    task automatic set_src(input logic [23:0] s0, input logic [23:0] s1);
        src_data_i = {s1, s0};
    endtask

    task automatic all_unity();
        for (int i = 0; i < NUM_IN; i++) begin
            for (int c = 0; c < NUM_CH; c++) set_vol(i, c, UNITY);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        tag_cnt = 0;
        rst     = 1'b1;
        pop_i   = '0;
        clr_i   = 1'b0;
        mute_i  = '0;
        src_en  = 2'b11;
        vol_i   = '0;
        all_unity();
        set_src(24'h0, 24'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {data_o, ack_o, src_pop_o, underrun_o}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // unity sum with 5-cycle latency
        set_src(24'h100000, 24'h200000);
        issue(2'b01, 2'b01, 24'h300000, 5);
        drain(50);

        // positive and negative saturation
        set_src(24'h700000, 24'h700000);
        issue(2'b01, 2'b01, 24'h7FFFFF, 5);
        drain(50);
        set_src(24'h900000, 24'h900000);
        issue(2'b01, 2'b01, 24'h800000, 5);
        drain(50);

        // half gain with floor rounding
        set_vol(0, 0, HALF);
        set_src(24'h000003, 24'h000000);
        issue(2'b01, 2'b01, 24'h000001, 5);
        drain(50);
        set_src(24'hFFFFFD, 24'h000000);
        issue(2'b01, 2'b01, 24'hFFFFFE, 5);
        drain(50);
        all_unity();

        // channel 1 uses its own gain column
        set_vol(1, 1, HALF);
        set_src(24'h100000, 24'h200000);
        issue(2'b10, 2'b10, 24'h200000, 5);
        drain(50);
        all_unity();

        // muted source contributes nothing
        mute_i = 2'b10;
        issue(2'b01, 2'b01, 24'h100000, 5);
        drain(50);
        mute_i = 2'b00;

        // source 1 silent: timeout, zero substitution, sticky underrun, clear
        src_en = 2'b01;
        set_src(24'h123456, 24'h222222);
        issue(2'b01, 2'b01, 24'h123456, 2 + TIMEOUT + 1 + NUM_IN + 1);
        drain(400);
        check("underrun_set", 32'(underrun_o), 32'h2);
        @(posedge clk);
        #1;
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        check("underrun_clr", 32'(underrun_o), 32'h0);
        src_en = 2'b11;

        // two channels at once, repeat pop on still-pending ch1 merges
        set_src(24'h010000, 24'h020000);
        @(posedge clk);
        #1;
        pop_i = 2'b11;
        push_exp(2'b01, 24'h030000, cyc + 5);
        push_exp(2'b10, 24'h030000, -1);
        @(posedge clk);
        #1;
        pop_i = 2'b00;
        @(posedge clk);
        #1;
        pop_i = 2'b10;
        @(posedge clk);
        #1;
        pop_i = 2'b00;
        drain(60);
        repeat (30) @(posedge clk);

        // reset while waiting on silent sources aborts without an ack
        src_en = 2'b00;
        issue(2'b01, 2'b00, 24'h0, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wait", {data_o, ack_o, src_pop_o, underrun_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        src_en = 2'b11;
        repeat (300) @(posedge clk);
        set_src(24'h000010, 24'h000020);
        issue(2'b01, 2'b01, 24'h000030, 5);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
